// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
// Multi-cycle adder: WIDTH-bit operands are summed CHUNK bits per clock,
// least-significant chunk first, with the inter-chunk carry held in a
// register. A start/busy/done handshake frames each operation; sum, cout
// and overflow are registered and only change on the completing edge.
//
// Optional feature: define CHUNKED_ADDER_SUB_EN to add a 'sub' input that
// selects a - b - cin (computed as a + ~b + ~cin) instead of a + b + cin.
//
// Parameter constraints: WIDTH >= 1 and CHUNK must divide WIDTH exactly.
module chunked_serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] LAST_K = KW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             last;

    // Operand registers, inter-chunk carry, chunk index and partial sum
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] work_sum;

    // Ripple-slice signals for the chunk currently selected by k
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_msb_cin;
    logic             ripple;
    logic [WIDTH-1:0] next_work_sum;

    // Operand conditioning applied at acceptance time
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef CHUNKED_ADDER_SUB_EN
    // Subtraction reuses the adder: a - b - cin == a + ~b + ~cin.
    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = sub ? ~cin : cin;
    end
`else
    // Addition only: operands pass straight through.
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
    end
`endif

    assign busy = (state == RUN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode.
    always_comb begin
        // NOTE: every output of this block gets a default before the case so
        // no path leaves a signal unassigned, which would infer a latch.
        next_state = state;
        accept     = 1'b0;
        last       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (k == LAST_K) begin
                    last       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // CHUNK-bit ripple slice on the selected chunk; also exposes the carry
    // into the top bit of the slice, which on the last chunk is the carry
    // into the operand MSB.
    always_comb begin
        // NOTE: blocking assignments here model the carry rippling through
        // the slice bit by bit within one combinational evaluation.
        a_chunk       = CHUNK'(a_reg >> (int'(k) * CHUNK));
        b_chunk       = CHUNK'(b_reg >> (int'(k) * CHUNK));
        slice_sum     = '0;
        slice_msb_cin = carry;
        ripple        = carry;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                slice_msb_cin = ripple;
            end
            slice_sum[i] = a_chunk[i] ^ b_chunk[i] ^ ripple;
            ripple       = (a_chunk[i] & b_chunk[i]) | (ripple & (a_chunk[i] ^ b_chunk[i]));
        end
        slice_cout    = ripple;
        // work_sum is cleared on acceptance, so OR-ing places the chunk.
        next_work_sum = work_sum | (WIDTH'(slice_sum) << (int'(k) * CHUNK));
    end

    // Datapath: latch operands on accept, process one chunk per RUN cycle,
    // load the output registers and pulse done on the last chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            k        <= '0;
            work_sum <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done <= 1'b0;
            if (accept) begin
                a_reg    <= a;
                b_reg    <= b_eff;
                carry    <= cin_eff;
                k        <= '0;
                work_sum <= '0;
            end else if (state == RUN) begin
                work_sum <= next_work_sum;
                carry    <= slice_cout;
                if (last) begin
                    k        <= '0;
                    sum      <= next_work_sum;
                    cout     <= slice_cout;
                    overflow <= slice_msb_cin ^ slice_cout;
                    done     <= 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder
// Scoreboard bench for chunked_serial_adder (WIDTH=16, CHUNK=4). Expected
// results come from a signed/unsigned integer model and are queued when a
// start is driven; the done monitor pops and compares them, including the
// cycle on which done arrives. Define CHUNKED_ADDER_SUB_EN to also exercise
// the subtract mode.
module tb_chunked_serial_adder;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           due;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;

    exp_t         sbq[$];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] held_sum = '0;

    chunked_serial_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic s, input int due);
        exp_t        e;
        int          sx;
        int          sy;
        int          full;
        logic [W:0]  r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r      = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
            e.cout = ~r[W];
            full   = sx - sy - int'(ci);
        end else begin
            r      = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            e.cout = r[W];
            full   = sx + sy + int'(ci);
        end
        e.sum = r[W-1:0];
        e.ovf = (full > 32767) || (full < -32768);
        e.due = due;
        return e;
    endfunction

    // Drive start from the current negedge; acceptance happens on the next
    // posedge. Operands are scrambled afterwards since they may change freely.
    task automatic drive_start(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci, input logic s, input bit accepted);
        a     = x;
        b     = y;
        cin   = ci;
`ifdef CHUNKED_ADDER_SUB_EN
        sub   = s;
`endif
        start = 1'b1;
        if (accepted) sbq.push_back(model(x, y, ci, s, cyc + 1 + N));
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic s);
        @(negedge clk);
        drive_start(x, y, ci, s, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_sum"}, 32'(sum), 32'd0);
        check({tag, "_cout"}, 32'(cout), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Scoreboard monitor: compare on done, check outputs hold while busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_sum = '0;
        end else begin
            if (busy && !done) check("hold_sum", 32'(sum), 32'(held_sum));
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("sum", 32'(sum), 32'(e.sum));
                    check("cout", 32'(cout), 32'(e.cout));
                    check("overflow", 32'(overflow), 32'(e.ovf));
                    check("latency", 32'(cyc), 32'(e.due));
                    check("busy_at_done", 32'(busy), 32'd0);
                    held_sum = e.sum;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Basic add with busy profile: high for N cycles, low at done.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0);
        check("busy_c1", 32'(busy), 32'd1);
        for (int i = 2; i <= N; i++) begin
            @(negedge clk);
            check("busy_run", 32'(busy), 32'd1);
        end
        @(negedge clk);
        check("busy_end", 32'(busy), 32'd0);
        check("done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        wait_idle();

        // Full carry ripple and signed overflow corners.
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0); wait_idle();
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0); wait_idle();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0); wait_idle();
        issue(16'h8000, 16'h8000, 1'b0, 1'b0); wait_idle();

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(16'h0010, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        drive_start(16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!seen) check("done_wait_timeout", 32'd1, 32'd0);
        end
        drive_start(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        wait_idle();

        // Asynchronous reset between E2 and E3 abandons the operation.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0);
        void'(sbq.pop_back());
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        issue(16'h0003, 16'h0004, 1'b0, 1'b0); wait_idle();

`ifdef CHUNKED_ADDER_SUB_EN
        issue(16'h0005, 16'h0007, 1'b0, 1'b1); wait_idle();
        issue(16'h8000, 16'h0001, 1'b0, 1'b1); wait_idle();
        issue(16'h0003, 16'h0001, 1'b1, 1'b1); wait_idle();
`endif

        // Random operands.
        for (int i = 0; i < 8; i++) begin
            logic s = 1'b0;
`ifdef CHUNKED_ADDER_SUB_EN
            s = 1'($urandom);
`endif
            issue(W'($urandom), W'($urandom), 1'($urandom), s);
            wait_idle();
        end

        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
